// File: rtl/mux8_frame_serializer.sv
// mux8_frame_serializer: serializes an accepted byte through the 3-bit mux select, one bit per slot.
// Optional even-parity slot after the data bits when MUX8_SERIAL_PARITY_EN is defined.
module mux8_frame_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] sel,
    output logic       out_bit,
    output logic       out_valid,
    output logic       out_last,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef MUX8_SERIAL_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif
    localparam logic [2:0] START    = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] END_IDX  = MSB_FIRST ? 3'd0 : 3'd7;
    localparam logic [3:0] HOLD_MAX = 4'(BIT_CYCLES - 1);

    logic [1:0] state;
    logic [7:0] data_reg;
    logic [3:0] hold_cnt;
    logic       mux_bit;
    logic       slot_end;
    logic       end_bit;
    logic       accept;

    assign slot_end = hold_cnt == HOLD_MAX;
    assign end_bit  = state == SHIFT && sel == END_IDX;
`ifdef MUX8_SERIAL_PARITY_EN
    assign out_last = state == PARITY;
    assign out_bit  = state == SHIFT ? mux_bit : state == PARITY ? ^data_reg : 1'b0;
`else
    assign out_last = end_bit;
    assign out_bit  = state == SHIFT ? mux_bit : 1'b0;
`endif
    // Ready in the final cycle of the final slot lets the next frame follow with no gap.
    assign in_ready  = state == IDLE || (out_last && slot_end);
    assign accept    = in_valid && in_ready;
    assign out_valid = state != IDLE;
    assign busy      = out_valid;

    always_comb begin
        case (sel)
            3'd0:    mux_bit = data_reg[0];
            3'd1:    mux_bit = data_reg[1];
            3'd2:    mux_bit = data_reg[2];
            3'd3:    mux_bit = data_reg[3];
            3'd4:    mux_bit = data_reg[4];
            3'd5:    mux_bit = data_reg[5];
            3'd6:    mux_bit = data_reg[6];
            default: mux_bit = data_reg[7];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            data_reg <= '0;
            sel      <= START;
            hold_cnt <= '0;
        end else if (accept) begin
            state    <= SHIFT;
            data_reg <= in_data;
            sel      <= START;
            hold_cnt <= '0;
        end else if (state != IDLE) begin
            if (!slot_end) begin
                hold_cnt <= hold_cnt + 4'd1;
            end else begin
                hold_cnt <= '0;
                if (out_last) begin
                    state <= IDLE;
                    sel   <= START;
`ifdef MUX8_SERIAL_PARITY_EN
                end else if (end_bit) begin
                    state <= PARITY;
`endif
                end else begin
                    sel <= MSB_FIRST ? sel - 3'd1 : sel + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mux8_frame_serializer.sv
// tb_mux8_frame_serializer: directed checks of two serializer instances (1-cycle LSB-first, 3-cycle MSB-first).
// Expected slot count follows MUX8_SERIAL_PARITY_EN.
module tb_mux8_frame_serializer;
`ifdef MUX8_SERIAL_PARITY_EN
    localparam int NS = 9;
`else
    localparam int NS = 8;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d0 = '0, d1 = '0;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic       ir0, ob0, ov0, ol0, b0, ir1, ob1, ov1, ol1, b1;
    logic [2:0] s0, s1;
    int         compared = 0;
    int         mismatched = 0;

    mux8_frame_serializer u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(ir0),
        .sel(s0), .out_bit(ob0), .out_valid(ov0), .out_last(ol0), .busy(b0)
    );

    mux8_frame_serializer #(.BIT_CYCLES(3), .MSB_FIRST(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(ir1),
        .sel(s1), .out_bit(ob1), .out_valid(ov1), .out_last(ol1), .busy(b1)
    );

    always #5 clk = ~clk;

    // Vector layout: {out_valid, out_last, in_ready, busy, sel[2:0], out_bit}
    task automatic run_frame0(input logic [7:0] d, input logic nv, input logic [7:0] nd);
        logic [7:0] exp, act;
        for (int s = 0; s < NS; s++) begin
            @(negedge clk);
            exp = {1'b1, s == NS - 1, s == NS - 1, 1'b1, s < 8 ? 3'(s) : 3'd7, s < 8 ? d[s] : ^d};
            act = {ov0, ol0, ir0, b0, s0, ob0};
            compared++;
            if (act !== exp) begin
                mismatched++;
                $display("FAIL frame0 d=%h slot %0d: got %b want %b", d, s, act, exp);
            end
            if (s == 0) begin
                v0 = nv;
                d0 = nd;
            end
        end
    endtask

    task automatic check_idle0(input string name);
        @(negedge clk);
        compared++;
        if ({ov0, ol0, ir0, b0, s0, ob0} !== 8'b0010_0000) begin
            mismatched++;
            $display("FAIL %s: got %b want 00100000", name, {ov0, ol0, ir0, b0, s0, ob0});
        end
    endtask

    task automatic test_reset;
        v0 = 1'b1; d0 = 8'hFF; v1 = 1'b1; d1 = 8'hFF;
        @(negedge clk);
        compared++;
        if ({ov0, ol0, ir0, b0, s0, ob0} !== 8'b0010_0000) begin
            mismatched++;
            $display("FAIL reset dut0: got %b want 00100000", {ov0, ol0, ir0, b0, s0, ob0});
        end
        compared++;
        if ({ov1, ol1, ir1, b1, s1, ob1} !== 8'b0010_1110) begin
            mismatched++;
            $display("FAIL reset dut1: got %b want 00101110", {ov1, ol1, ir1, b1, s1, ob1});
        end
        v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
    endtask

    task automatic test_lsb_frame;
        @(negedge clk);
        v0 = 1'b1; d0 = 8'b1011_0010;
        run_frame0(8'b1011_0010, 1'b0, 8'h00);
        check_idle0("lsb_frame idle");
    endtask

    task automatic test_back_to_back;
        v0 = 1'b1; d0 = 8'hA5;
        run_frame0(8'hA5, 1'b1, 8'h3C);
        run_frame0(8'h3C, 1'b0, 8'h00);
        check_idle0("back_to_back idle");
    endtask

    task automatic test_msb_hold3;
        logic [7:0] exp, act;
        logic [7:0] d;
        int s;
        d = 8'h81;
        @(negedge clk);
        v1 = 1'b1; d1 = d;
        for (int c = 0; c < NS * 3; c++) begin
            @(negedge clk);
            s = c / 3;
            exp = {1'b1, s == NS - 1, c == NS * 3 - 1, 1'b1, s < 8 ? 3'(7 - s) : 3'd0, s < 8 ? d[7 - s] : ^d};
            act = {ov1, ol1, ir1, b1, s1, ob1};
            compared++;
            if (act !== exp) begin
                mismatched++;
                $display("FAIL msb_hold3 cycle %0d: got %b want %b", c, act, exp);
            end
            v1 = 1'b0;
        end
        @(negedge clk);
        compared++;
        if ({ov1, ol1, ir1, b1, s1, ob1} !== 8'b0010_1110) begin
            mismatched++;
            $display("FAIL msb_hold3 idle: got %b want 00101110", {ov1, ol1, ir1, b1, s1, ob1});
        end
    endtask

    task automatic test_reset_mid_frame;
        v0 = 1'b1; d0 = 8'h5A;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            v0 = 1'b0;
        end
        compared++;
        if (s0 !== 3'd4) begin
            mismatched++;
            $display("FAIL mid_reset pre sel: got %0d want 4", s0);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if ({ov0, ol0, b0, s0} !== 6'b000_000) begin
            mismatched++;
            $display("FAIL mid_reset async: got %b want 000000", {ov0, ol0, b0, s0});
        end
        @(negedge clk);
        rst_n = 1'b1; v0 = 1'b1; d0 = 8'hFF;
        run_frame0(8'hFF, 1'b0, 8'h00);
        check_idle0("mid_reset idle");
    endtask

    task automatic test_parity;
        v0 = 1'b1; d0 = 8'h07;
        run_frame0(8'h07, 1'b1, 8'h03);
        run_frame0(8'h03, 1'b0, 8'h00);
        check_idle0("parity idle");
    endtask

    initial begin
        test_reset;
        test_lsb_frame;
        test_back_to_back;
        test_msb_hold3;
        test_reset_mid_frame;
        test_parity;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
